uart_rx_ext: RTL and testbench

UART_RX_EXT -- requirements
Module: uart_rx_ext

---
 rtl/uart_rx_ext_if.sv | 16 +
 rtl/uart_rx_ext.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ext_if.sv
// Receive-side handshake and status bundle of uart_rx_ext.
interface uart_rx_ext_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       frame_err;
   logic       parity_err;
   logic       overrun;
   logic       idle;
   logic       endofpacket;

   modport master (output data, valid, frame_err, parity_err, overrun, idle, endofpacket,
                   input  ready);
   modport slave  (input  data, valid, frame_err, parity_err, overrun, idle, endofpacket,
                   output ready);
endinterface

// File: rtl/uart_rx_ext.sv
// 16x oversampling UART receiver with majority-vote bit decision, break and idle detection.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FWFT receive FIFO instead of a holding register.
module uart_rx_ext #(
   parameter int CLK_FREQ   = 12000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int IDLE_BITS  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rxd,
   uart_rx_ext_if.master rx
);
   localparam longint unsigned TICK_INC_L =
      ((64'd16 * BAUD * (64'd1 << 17)) + CLK_FREQ / 2) / CLK_FREQ;
   localparam logic [16:0] TICK_INC = 17'(TICK_INC_L);
   localparam int IW = $clog2(IDLE_BITS + 1);

   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
      $error("uart_rx_ext: DATA_BITS must be 5..8");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_ext: FIFO_DEPTH must be a power of 2, at least 2");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   logic [16:0]   acc;
   logic [17:0]   acc_sum;
   logic          tick;
   logic [1:0]    sync;
   logic [1:0]    sync_age;
   logic          rxd_s;
   state_t        state;
   logic [3:0]    os_cnt;
   logic          s7, s8;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          par_bad;
   logic          armed;
   logic          started;
   logic [IW-1:0] idle_cnt;
   logic          idle_q;
   logic          push;
   logic [7:0]    push_data;
   logic          frame_err_q, parity_err_q, eop_q, overrun_q;
   logic          vote, mid_tick, end_tick, par_exp;
   logic          pop;

   assign acc_sum = {1'b0, acc} + {1'b0, TICK_INC};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= '0;
         tick     <= 1'b0;
         sync     <= 2'b11;
         sync_age <= 2'b00;
      end else begin
         acc      <= acc_sum[16:0];
         tick     <= acc_sum[17];
         sync     <= {sync[0], rxd};
         sync_age <= {sync_age[0], 1'b1};
      end
   end

   assign rxd_s    = sync[1];
   assign vote     = (s7 & s8) | (s7 & rxd_s) | (s8 & rxd_s);
   assign mid_tick = tick && (os_cnt == 4'd9);
   assign end_tick = tick && (os_cnt == 4'd15);
   assign par_exp  = (PARITY == 2) ? ~^shreg : ^shreg;

   // A start needs the line seen high first, so a line held low across reset is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         os_cnt       <= '0;
         s7           <= 1'b1;
         s8           <= 1'b1;
         bit_idx      <= '0;
         shreg        <= '0;
         par_bad      <= 1'b0;
         armed        <= 1'b0;
         started      <= 1'b0;
         idle_cnt     <= IW'(IDLE_BITS);
         idle_q       <= 1'b1;
         push         <= 1'b0;
         push_data    <= '0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         eop_q        <= 1'b0;
      end else begin
         push         <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         eop_q        <= 1'b0;
         if (tick) os_cnt <= os_cnt + 4'd1;
         if (tick && os_cnt == 4'd7) s7 <= rxd_s;
         if (tick && os_cnt == 4'd8) s8 <= rxd_s;
         if (state != S_IDLE) begin
            idle_cnt <= '0;
            idle_q   <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (end_tick && idle_cnt != IW'(IDLE_BITS)) begin
                  idle_cnt <= idle_cnt + IW'(1);
                  if (idle_cnt == IW'(IDLE_BITS - 1)) begin
                     idle_q  <= 1'b1;
                     eop_q   <= started;
                     started <= 1'b0;
                  end
               end
               if (!armed) begin
                  armed <= rxd_s && sync_age[1];
               end else if (!rxd_s) begin
                  state  <= S_START;
                  os_cnt <= '0;
                  armed  <= 1'b0;
               end
            end
            S_START: begin
               if (mid_tick) begin
                  if (!vote) begin
                     state   <= S_DATA;
                     bit_idx <= '0;
                     shreg   <= '0;
                     par_bad <= 1'b0;
                     started <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_DATA: begin
               if (mid_tick) begin
                  shreg[bit_idx] <= vote;
                  bit_idx        <= bit_idx + 3'd1;
                  if (bit_idx == 3'(DATA_BITS - 1))
                     state <= (PARITY != 0) ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               if (mid_tick) begin
                  par_bad <= (vote != par_exp);
                  state   <= S_STOP;
               end
            end
            S_STOP: begin
               if (mid_tick) begin
                  if (!vote) begin
                     frame_err_q <= 1'b1;
                     state       <= S_BREAK;
                  end else if (par_bad) begin
                     parity_err_q <= 1'b1;
                     state        <= S_IDLE;
                  end else begin
                     push      <= 1'b1;
                     push_data <= shreg;
                     state     <= S_IDLE;
                  end
               end
            end
            S_BREAK: begin
               if (rxd_s) begin
                  state <= S_IDLE;
                  armed <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef UART_RX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wptr, rptr;
   logic        full, empty, wr_en;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign pop   = !empty && rx.ready;
   assign wr_en = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr[AW-1:0]] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= push && full && !pop;
         if (wr_en) wptr <= wptr + (AW+1)'(1);
         if (pop)   rptr <= rptr + (AW+1)'(1);
      end
   end

   assign rx.valid = !empty;
   assign rx.data  = empty ? 8'd0 : mem[rptr[AW-1:0]];
`else
   logic [7:0] hold;
   logic       hold_vld;

   assign pop = hold_vld && rx.ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold      <= '0;
         hold_vld  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= push && hold_vld && !pop;
         if (push && (!hold_vld || pop)) begin
            hold     <= push_data;
            hold_vld <= 1'b1;
         end else if (pop) begin
            hold_vld <= 1'b0;
         end
      end
   end

   assign rx.valid = hold_vld;
   assign rx.data  = hold;
`endif

   assign rx.frame_err   = frame_err_q;
   assign rx.parity_err  = parity_err_q;
   assign rx.overrun     = overrun_q;
   assign rx.idle        = idle_q;
   assign rx.endofpacket = eop_q;
endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: default-config instance plus a 7-bit odd-parity instance.
`timescale 1ns/1ps
module tb_uart_rx_ext;
   localparam int BIT_CLKS = 104;
`ifdef UART_RX_FIFO_EN
   localparam int NKEEP = 4;
`else
   localparam int NKEEP = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   logic rxd;
   logic rxd_p;
   int   total = 0;
   int   bad = 0;
   int   n_pop = 0, n_vhigh = 0, n_frame = 0, n_par = 0, n_ovr = 0, n_eop = 0;
   int   np_pop = 0, np_par = 0, np_frame = 0;
   int   base;
   logic [7:0] exp_d, exp_p;
   logic [7:0] q[$];
   logic [7:0] qp[$];

   always #5 clk = ~clk;

   uart_rx_ext_if bus ();
   uart_rx_ext_if bus_p ();

   uart_rx_ext dut (.clk(clk), .rst(rst), .rxd(rxd), .rx(bus));
   uart_rx_ext #(.DATA_BITS(7), .PARITY(2)) dut_p (.clk(clk), .rst(rst), .rxd(rxd_p), .rx(bus_p));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic line(input logic v, input int bits);
      rxd = v;
      clks(bits * BIT_CLKS);
   endtask

   task automatic send(input logic [7:0] ch, input logic stop);
      line(1'b0, 1);
      for (int i = 0; i < 8; i++) line(ch[i], 1);
      line(stop, 1);
   endtask

   task automatic send_p(input logic [6:0] ch, input logic par);
      rxd_p = 1'b0;
      clks(BIT_CLKS);
      for (int i = 0; i < 7; i++) begin
         rxd_p = ch[i];
         clks(BIT_CLKS);
      end
      rxd_p = par;
      clks(BIT_CLKS);
      rxd_p = 1'b1;
      clks(BIT_CLKS);
   endtask

   // Scoreboard and pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.valid) n_vhigh++;
         if (bus.frame_err) n_frame++;
         if (bus.parity_err) n_par++;
         if (bus.overrun) n_ovr++;
         if (bus.endofpacket) n_eop++;
         if (bus_p.parity_err) np_par++;
         if (bus_p.frame_err) np_frame++;
         if (bus.valid && bus.ready) begin
            n_pop++;
            total++;
            assert (q.size() > 0) else begin
               bad++;
               $error("FAIL pop_extra got=%02h want=none", bus.data);
            end
            if (q.size() > 0) begin
               exp_d = q.pop_front();
               check("data", {24'd0, bus.data}, {24'd0, exp_d});
            end
         end
         if (bus_p.valid && bus_p.ready) begin
            np_pop++;
            total++;
            assert (qp.size() > 0) else begin
               bad++;
               $error("FAIL pop_p_extra got=%02h want=none", bus_p.data);
            end
            if (qp.size() > 0) begin
               exp_p = qp.pop_front();
               check("data_p", {24'd0, bus_p.data}, {24'd0, exp_p});
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      rxd = 1'b1;
      rxd_p = 1'b1;
      bus.ready = 1'b1;
      bus_p.ready = 1'b1;
      clks(3);
      check("rst_valid", {31'd0, bus.valid}, 0);
      check("rst_data", {24'd0, bus.data}, 0);
      check("rst_idle", {31'd0, bus.idle}, 1);
      check("rst_flags", {28'd0, bus.frame_err, bus.parity_err, bus.overrun, bus.endofpacket}, 0);
      rst = 1'b0;
      clks(10);

      // Short glitch: rejected, no flags, idle returns without endofpacket.
      rxd = 1'b0;
      clks(26);
      rxd = 1'b1;
      clks(30);
      check("glitch_idle_drop", {31'd0, bus.idle}, 0);
      clks(20 * BIT_CLKS);
      check("glitch_pops", n_pop, 0);
      check("glitch_flags", n_frame + n_par + n_ovr, 0);
      check("glitch_idle", {31'd0, bus.idle}, 1);
      check("glitch_no_eop", n_eop, 0);

      // Two characters, ready high.
      q.push_back(8'h55);
      q.push_back(8'hA3);
      send(8'h55, 1'b1);
      send(8'hA3, 1'b1);
      clks(2 * BIT_CLKS);
      check("pair_pops", n_pop, 2);
      check("pair_valid_cycles", n_vhigh, 2);
      check("pair_flags", n_frame + n_par + n_ovr, 0);
      clks(18 * BIT_CLKS);
      check("pair_idle", {31'd0, bus.idle}, 1);
      check("pair_eop", n_eop, 1);

      // Framing error followed by a long break, then recovery.
      send(8'h00, 1'b0);
      line(1'b0, 19);
      check("break_frame", n_frame, 1);
      check("break_no_char", n_pop, 2);
      check("break_no_par", n_par, 0);
      line(1'b1, 2);
      q.push_back(8'h12);
      send(8'h12, 1'b1);
      clks(2 * BIT_CLKS);
      check("after_break_pops", n_pop, 3);
      check("after_break_frame", n_frame, 1);

      // Overrun with the consumer stalled.
      bus.ready = 1'b0;
      for (int k = 0; k <= NKEEP; k++) begin
         if (k < NKEEP) q.push_back(8'h30 + 8'(k));
         send(8'h30 + 8'(k), 1'b1);
      end
      clks(2 * BIT_CLKS);
      check("ovr_count", n_ovr, 1);
      check("ovr_valid_held", {31'd0, bus.valid}, 1);
      check("ovr_head", {24'd0, bus.data}, 32'h30);
      bus.ready = 1'b1;
      clks(10);
      check("ovr_drain_pops", n_pop, 3 + NKEEP);
      check("ovr_queue_empty", q.size(), 0);
      check("ovr_no_frame", n_frame, 1);

      // 7-bit odd parity: wrong parity then correct parity for 0x41.
      send_p(7'h41, 1'b0);
      clks(2 * BIT_CLKS);
      check("par_err", np_par, 1);
      check("par_no_valid", np_pop, 0);
      check("par_no_frame", np_frame, 0);
      qp.push_back(8'h41);
      send_p(7'h41, 1'b1);
      clks(2 * BIT_CLKS);
      check("par_good_pop", np_pop, 1);
      check("par_good_no_err", np_par, 1);

      // Reset during bit 4 (a low bit), line held low past release.
      base = n_pop;
      line(1'b0, 1);
      for (int i = 0; i < 4; i++) line(1'b1, 1);
      rxd = 1'b0;
      clks(BIT_CLKS / 2);
      rst = 1'b1;
      clks(2);
      check("mid_rst_valid", {31'd0, bus.valid}, 0);
      check("mid_rst_data", {24'd0, bus.data}, 0);
      check("mid_rst_idle", {31'd0, bus.idle}, 1);
      check("mid_rst_flags", {28'd0, bus.frame_err, bus.parity_err, bus.overrun, bus.endofpacket}, 0);
      rst = 1'b0;
      line(1'b0, 3);
      line(1'b1, 2);
      check("mid_rst_no_char", n_pop, base);
      check("mid_rst_no_frame", n_frame, 1);
      q.push_back(8'h7E);
      send(8'h7E, 1'b1);
      clks(2 * BIT_CLKS);
      check("after_rst_pop", n_pop, base + 1);
      check("final_q_empty", q.size(), 0);
      check("final_qp_empty", qp.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
